alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + accumulator front end for a 32-bit combinational ALU.
// Commands are queued, issued one per cycle, and the ALU result is written back into acc.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic        cmd_load,
  input  logic [31:0] cmd_data,
  input  logic        hold,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] acc,
  output logic        acc_zero,
  output logic        res_valid,
  output logic [AW:0] fifo_count
);

  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [3:0]  OP_ADD = 4'b0010;

  typedef struct packed {
    logic        load;
    logic [3:0]  op;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // ---------------------------------------------------------------- FIFO
  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  cmd_t          head;

  // ---------------------------------------------------------------- issue / acc
  state_t        state_q, state_d;
  cmd_t          iss_q, iss_d;
  logic [31:0]   acc_q, acc_d;
  logic          acc_zero_q, acc_zero_d;
  logic          res_valid_q, res_valid_d;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never opens a slot for the incoming command.
  always_comb begin
    cmd_ready = (count_q != FULL);
    push      = cmd_valid && cmd_ready;
    pop       = (count_q != '0) && !hold;
    head      = mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{load: cmd_load, op: cmd_op, data: cmd_data};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state: the command held in the issue regs retires at the end of
  // every EXEC cycle; a new head is taken whenever the pop condition holds.
  always_comb begin
    state_d     = state_q;
    iss_d       = iss_q;
    acc_d       = acc_q;
    acc_zero_d  = acc_zero_q;
    res_valid_d = 1'b0;

    if (state_q == EXEC) begin
      acc_d       = iss_q.load ? iss_q.data : alu_result;
      acc_zero_d  = iss_q.load ? (iss_q.data == 32'd0) : alu_zero;
      res_valid_d = 1'b1;
    end

    if (pop) begin
      iss_d   = head;
      state_d = EXEC;
    end else if (state_q == EXEC) begin
      state_d = IDLE;
    end
  end

  // ALU drive comes only from registers; loads present an ADD whose result is dropped.
  always_comb begin
    alu_op1 = acc_q;
    alu_op2 = 32'd0;
    alu_op  = 4'b0000;
    if (state_q == EXEC) begin
      alu_op2 = iss_q.data;
      alu_op  = iss_q.load ? OP_ADD : iss_q.op;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      iss_q       <= '0;
      acc_q       <= 32'd0;
      acc_zero_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      iss_q       <= iss_d;
      acc_q       <= acc_d;
      acc_zero_q  <= acc_zero_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign acc        = acc_q;
  assign acc_zero   = acc_zero_q;
  assign res_valid  = res_valid_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU stub, in-order command queue model,
// directed scenarios followed by randomized traffic.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic        cmd_load = 1'b0;
  logic [31:0] cmd_data = 32'd0;
  logic        hold = 1'b0;
  logic [31:0] alu_op1, alu_op2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] acc;
  logic        acc_zero;
  logic        res_valid;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_load(cmd_load), .cmd_data(cmd_data), .hold(hold),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .acc(acc), .acc_zero(acc_zero), .res_valid(res_valid), .fifo_count(fifo_count)
  );

  // Reference ALU semantics; unsupported opcodes yield zero.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return a >> b[4:0];
      4'b1001: return a << b[4:0];
      4'b1010: return $unsigned($signed(a) >>> b[4:0]);
      4'b0101: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_op1, alu_op2);
  assign alu_zero   = (alu_result == 32'd0);

  typedef struct {
    logic        ld;
    logic [3:0]  op;
    logic [31:0] d;
  } tcmd_t;

  tcmd_t       exp_q[$];
  logic [31:0] seen_q[$];
  logic [31:0] model_acc = 32'd0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          chk_cnt = 0;
  int          pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: note what the edge will do, step past it, then update the
  // model and score any completed command.
  task automatic tick();
    bit    rst = !resetn;
    bit    acc_ev = resetn && cmd_valid && cmd_ready;
    tcmd_t c = '{cmd_load, cmd_op, cmd_data};
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      model_acc = 32'd0;
    end else if (acc_ev) begin
      exp_q.push_back(c);
    end
    if (res_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("res_valid_unexpected", 32'(res_valid), 32'd0);
      end else begin
        c = exp_q.pop_front();
        model_acc = c.ld ? c.d : alu_f(c.op, model_acc, c.d);
        seen_q.push_back(acc);
        check("acc", acc, model_acc);
        check("acc_zero", 32'(acc_zero), 32'(model_acc == 32'd0));
      end
    end
  endtask

  task automatic send(input logic ld, input logic [3:0] op, input logic [31:0] d);
    bit rdy;
    int n = 0;
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_data  = d;
    do begin
      rdy = cmd_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("send_accept_timeout", 32'(rdy), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    hold = 1'b0;
    cmd_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_fifo_count", 32'(fifo_count), 32'd0);
  endtask

  logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100,
                           4'b1000, 4'b1001, 4'b1010, 4'b0101, 4'b1111};

  initial begin
    int b;
    int p;

    // reset state
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    check("rst_acc", acc, 32'd0);
    check("rst_acc_zero", 32'(acc_zero), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_op2", alu_op2, 32'd0);

    // load 5, ADD 3: exact latency and back-to-back pulses
    send(1'b1, 4'b0000, 32'd5);
    send(1'b0, 4'b0010, 32'd3);
    check("load_alu_op_forced", 32'(alu_op), 32'h2);
    check("load_alu_op2", alu_op2, 32'd5);
    check("load_res_valid_early", 32'(res_valid), 32'd0);
    tick();
    check("pulse1", 32'(res_valid), 32'd1);
    check("pulse1_acc", acc, 32'd5);
    check("add_alu_op1", alu_op1, 32'd5);
    check("add_alu_op2", alu_op2, 32'd3);
    tick();
    check("pulse2", 32'(res_valid), 32'd1);
    check("pulse2_acc", acc, 32'd8);
    check("pulse2_acc_zero", 32'(acc_zero), 32'd0);
    tick();
    check("pulse_end", 32'(res_valid), 32'd0);
    check("idle_alu_op", 32'(alu_op), 32'd0);
    check("idle_alu_op2", alu_op2, 32'd0);
    check("idle_alu_op1", alu_op1, 32'd8);

    // SUB to zero, then zero flag through the load path
    send(1'b0, 4'b0110, 32'd8);
    tick();
    check("sub_alu_op", 32'(alu_op), 32'h6);
    check("sub_alu_op1", alu_op1, 32'd8);
    drain();
    check("sub_acc", acc, 32'd0);
    check("sub_acc_zero", 32'(acc_zero), 32'd1);
    send(1'b1, 4'b0000, 32'd9);
    send(1'b1, 4'b0000, 32'd0);
    drain();
    check("load0_acc", acc, 32'd0);
    check("load0_acc_zero", 32'(acc_zero), 32'd1);

    // hold fills the FIFO; no push-through on the releasing pop
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) send(1'b0, 4'b0010, 32'(i));
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("held_res_valid", 32'(res_valid), 32'd0);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 4'b0010; cmd_data = 32'd10;
    tick();
    tick();
    check("held_count", 32'(fifo_count), 32'd4);
    hold = 1'b0;
    tick();
    check("release_count", 32'(fifo_count), 32'd3);
    check("release_res_valid", 32'(res_valid), 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("burst_pulse", 32'(res_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("burst_pulse", 32'(res_valid), 32'd1);
    end
    drain();
    check("burst_acc", acc, 32'd20);

    // shift / xor chain
    b = seen_q.size();
    send(1'b1, 4'b0000, 32'h0F0);
    send(1'b0, 4'b1001, 32'd4);
    send(1'b0, 4'b1000, 32'd8);
    send(1'b0, 4'b0101, 32'h0FF);
    drain();
    check("shift_n", 32'(seen_q.size() - b), 32'd4);
    check("shift_0", seen_q[b],   32'h0F0);
    check("shift_1", seen_q[b+1], 32'hF00);
    check("shift_2", seen_q[b+2], 32'h00F);
    check("shift_3", seen_q[b+3], 32'h0F0);

    // SRA sign fill, signed SLT, unsupported opcode
    b = seen_q.size();
    send(1'b1, 4'b0000, 32'hFFFF_FFFF);
    send(1'b0, 4'b1010, 32'd4);
    send(1'b0, 4'b0100, 32'd0);
    send(1'b0, 4'b1111, 32'd7);
    drain();
    check("sra", seen_q[b],   32'hFFFF_FFFF);
    check("sra2", seen_q[b+1], 32'hFFFF_FFFF);
    check("slt", seen_q[b+2], 32'd1);
    check("unsup", seen_q[b+3], 32'd0);
    check("unsup_zero", 32'(acc_zero), 32'd1);

    // reset with three queued and one in EXEC
    send(1'b1, 4'b0000, 32'h55);
    drain();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 4'b0010, 32'd1);
    hold = 1'b0;
    tick();
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("mid_rst_acc", acc, 32'd0);
    check("mid_rst_acc_zero", 32'(acc_zero), 32'd1);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    p = pulses;
    repeat (6) tick();
    check("post_rst_pulses", 32'(pulses - p), 32'd0);
    check("post_rst_acc", acc, 32'd0);

    // randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      hold = ($urandom_range(0, 3) == 0) && (fifo_count < 3'd4);
      if ($urandom_range(0, 2) != 0) begin
        logic [3:0]  op;
        logic [31:0] d;
        op = ops[$urandom_range(0, 9)];
        d  = $urandom();
        if (op[3] && $urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 31));
        send($urandom_range(0, 3) == 0, op, d);
      end else begin
        tick();
      end
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
